// File: rtl/twiddle_mult_stage.sv
// Twiddle multiply stage for a radix-2 FFT butterfly path.
// The lower branch is multiplied by W32^k (9-bit signed, 7 fractional bits),
// rounded half up and saturated back to DW bits. The upper branch rides
// alongside unmodified so both lanes leave the stage on the same cycle.
// The twiddle index k comes from a 4-bit frame counter that drives an
// external combinational ROM.
//
// Handshake: valid-only streaming with no ready/backpressure. A sample is
// taken on every rising edge where in_valid is high; in_sof is meaningful
// only together with in_valid. Each accepted sample appears on the outputs
// exactly 3 cycles later with out_valid high, and output data holds its
// last value whenever out_valid is low.
module twiddle_mult_stage #(
  parameter int DW = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic                 in_sof,
  input  logic signed [DW-1:0] in_up_r,
  input  logic signed [DW-1:0] in_up_i,
  input  logic signed [DW-1:0] in_lo_r,
  input  logic signed [DW-1:0] in_lo_i,
  output logic [3:0]           rom_addr,
  input  logic signed [8:0]    w_r,
  input  logic signed [8:0]    w_i,
  output logic                 out_valid,
  output logic signed [DW-1:0] out_up_r,
  output logic signed [DW-1:0] out_up_i,
  output logic signed [DW-1:0] out_lo_r,
  output logic signed [DW-1:0] out_lo_i
);

  // Product, sum and post-shift widths.
  localparam int PW = DW + 9;
  localparam int SW = DW + 10;
  localparam int RW = SW - 7;

  localparam logic signed [SW-1:0] HALF    = SW'(64);
  localparam logic signed [RW-1:0] SAT_MAX = {4'b0000, {(DW-1){1'b1}}};
  localparam logic signed [RW-1:0] SAT_MIN = {4'b1111, {(DW-1){1'b0}}};

  // Twiddle index within the current 16-sample frame.
  logic [3:0] cnt;

  // Stage 1 registers.
  logic                 s1_valid;
  logic signed [DW-1:0] s1_up_r, s1_up_i, s1_lo_r, s1_lo_i;
  logic signed [8:0]    s1_w_r, s1_w_i;

  // Stage 2 registers.
  logic                 s2_valid;
  logic signed [DW-1:0] s2_up_r, s2_up_i;
  logic signed [PW-1:0] s2_rr, s2_ii, s2_ri, s2_ir;

  // Stage 3 combinational datapath.
  logic signed [SW-1:0] sum_r, sum_i;
  logic signed [RW-1:0] rnd_r, rnd_i;

  // Clamp a rounded result into the DW-bit signed range.
  function automatic logic signed [DW-1:0] sat(input logic signed [RW-1:0] v);
    if (v > SAT_MAX)      return SAT_MAX[DW-1:0];
    else if (v < SAT_MIN) return SAT_MIN[DW-1:0];
    else                  return v[DW-1:0];
  endfunction

  // A start-of-frame sample must see k = 0 in the same cycle, before the
  // counter has had a chance to restart.
  assign rom_addr = (in_valid && in_sof) ? 4'd0 : cnt;

  // Frame counter: advances only on accepted samples, wraps 15 -> 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= 4'd0;
    end else if (in_valid) begin
      cnt <= (in_sof ? 4'd0 : cnt) + 4'd1;
    end
  end

  // Stage 1: capture samples and the twiddle the ROM returned for them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_up_r  <= '0;
      s1_up_i  <= '0;
      s1_lo_r  <= '0;
      s1_lo_i  <= '0;
      s1_w_r   <= '0;
      s1_w_i   <= '0;
    end else begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_up_r <= in_up_r;
        s1_up_i <= in_up_i;
        s1_lo_r <= in_lo_r;
        s1_lo_i <= in_lo_i;
        s1_w_r  <= w_r;
        s1_w_i  <= w_i;
      end
    end
  end

  // Stage 2: four full-precision partial products.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid <= 1'b0;
      s2_up_r  <= '0;
      s2_up_i  <= '0;
      s2_rr    <= '0;
      s2_ii    <= '0;
      s2_ri    <= '0;
      s2_ir    <= '0;
    end else begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_up_r <= s1_up_r;
        s2_up_i <= s1_up_i;
        s2_rr   <= PW'(s1_lo_r) * PW'(s1_w_r);
        s2_ii   <= PW'(s1_lo_i) * PW'(s1_w_i);
        s2_ri   <= PW'(s1_lo_r) * PW'(s1_w_i);
        s2_ir   <= PW'(s1_lo_i) * PW'(s1_w_r);
      end
    end
  end

  // Complex combine with the rounding offset folded in, then an arithmetic
  // shift drops the 7 fractional twiddle bits (floor of x + 0.5).
  assign sum_r = SW'(s2_rr) - SW'(s2_ii) + HALF;
  assign sum_i = SW'(s2_ri) + SW'(s2_ir) + HALF;
  assign rnd_r = RW'(sum_r >>> 7);
  assign rnd_i = RW'(sum_i >>> 7);

  // Stage 3: saturate and register both lanes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_up_r  <= '0;
      out_up_i  <= '0;
      out_lo_r  <= '0;
      out_lo_i  <= '0;
    end else begin
      out_valid <= s2_valid;
      if (s2_valid) begin
        out_up_r <= s2_up_r;
        out_up_i <= s2_up_i;
        out_lo_r <= sat(rnd_r);
        out_lo_i <= sat(rnd_i);
      end
    end
  end

endmodule

// File: tb/tb_twiddle_mult_stage.sv
// Bench for twiddle_mult_stage: directed vectors plus randomized traffic,
// with a scoreboard queue fed by the driver and drained by a monitor.
module tb_twiddle_mult_stage;

  localparam int DW = 16;

  logic                 clk;
  logic                 rst;
  logic                 in_valid;
  logic                 in_sof;
  logic signed [DW-1:0] in_up_r, in_up_i, in_lo_r, in_lo_i;
  logic [3:0]           rom_addr;
  logic signed [8:0]    w_r, w_i;
  logic                 out_valid;
  logic signed [DW-1:0] out_up_r, out_up_i, out_lo_r, out_lo_i;

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int mk     = 0;   // reference frame position (next k)

  logic [4*DW-1:0] exp_q[$];
  int              exp_cyc_q[$];

  twiddle_mult_stage #(.DW(DW)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_sof   (in_sof),
    .in_up_r  (in_up_r),
    .in_up_i  (in_up_i),
    .in_lo_r  (in_lo_r),
    .in_lo_i  (in_lo_i),
    .rom_addr (rom_addr),
    .w_r      (w_r),
    .w_i      (w_i),
    .out_valid(out_valid),
    .out_up_r (out_up_r),
    .out_up_i (out_up_i),
    .out_lo_r (out_lo_r),
    .out_lo_i (out_lo_i)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- twiddle ROM: W32^k = cos - j*sin, truncated ----------------
  function automatic int trunc_q7(input real x);
    return $rtoi(128.0 * x + ((x >= 0.0) ? 1.0e-6 : -1.0e-6));
  endfunction

  function automatic int tw_re(input int k);
    return trunc_q7($cos(3.14159265358979 * k / 16.0));
  endfunction

  function automatic int tw_im(input int k);
    return -trunc_q7($sin(3.14159265358979 * k / 16.0));
  endfunction

  assign w_r = 9'(tw_re(int'(rom_addr)));
  assign w_i = 9'(tw_im(int'(rom_addr)));

  // ---------------- reference model ----------------
  function automatic logic signed [DW-1:0] round_sat(input longint x);
    real r;
    longint q;
    longint maxv;
    longint minv;
    maxv = (longint'(1) <<< (DW - 1)) - 1;
    minv = -(longint'(1) <<< (DW - 1));
    r = $floor(real'(x) / 128.0 + 0.5);
    q = longint'(r);
    if (q > maxv) q = maxv;
    if (q < minv) q = minv;
    return DW'(q);
  endfunction

  task automatic model(input logic signed [DW-1:0] lr, input logic signed [DW-1:0] li,
                       input int k,
                       output logic signed [DW-1:0] xr, output logic signed [DW-1:0] xi);
    longint wr, wi, a, b;
    wr = longint'(tw_re(k));
    wi = longint'(tw_im(k));
    a = longint'(lr);
    b = longint'(li);
    xr = round_sat(a * wr - b * wi);
    xi = round_sat(a * wi + b * wr);
  endtask

  // ---------------- comparison helper ----------------
  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- driver ----------------
  // has_exp selects spec-given expected lower outputs instead of the model.
  task automatic drive(input bit v, input bit sof,
                       input logic signed [DW-1:0] ur, input logic signed [DW-1:0] ui,
                       input logic signed [DW-1:0] lr, input logic signed [DW-1:0] li,
                       input bit has_exp,
                       input logic signed [DW-1:0] elr, input logic signed [DW-1:0] eli);
    int k;
    logic signed [DW-1:0] xr, xi;
    @(negedge clk);
    in_valid = v;
    in_sof   = sof;
    in_up_r  = ur;
    in_up_i  = ui;
    in_lo_r  = lr;
    in_lo_i  = li;
    #1;
    k = (v && sof) ? 0 : mk;
    check("rom_addr", longint'(rom_addr), longint'(k));
    if (v) begin
      model(lr, li, k, xr, xi);
      if (has_exp) begin
        xr = elr;
        xi = eli;
      end
      exp_q.push_back({ur, ui, xr, xi});
      exp_cyc_q.push_back(cyc + 3);
      mk = (k + 1) % 16;
    end
  endtask

  function automatic logic signed [DW-1:0] rnd_data();
    case ($urandom_range(0, 7))
      0:       return {1'b1, {(DW-1){1'b0}}};
      1:       return {1'b0, {(DW-1){1'b1}}};
      default: return DW'($urandom);
    endcase
  endfunction

  task automatic send(input bit sof);
    drive(1'b1, sof, rnd_data(), rnd_data(), rnd_data(), rnd_data(), 1'b0, '0, '0);
  endtask

  task automatic idle(input bit sof);
    drive(1'b0, sof, rnd_data(), rnd_data(), rnd_data(), rnd_data(), 1'b0, '0, '0);
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_out_valid"}, longint'(out_valid), 0);
    check({tag, "_out_up_r"}, longint'(out_up_r), 0);
    check({tag, "_out_up_i"}, longint'(out_up_i), 0);
    check({tag, "_out_lo_r"}, longint'(out_lo_r), 0);
    check({tag, "_out_lo_i"}, longint'(out_lo_i), 0);
    check({tag, "_rom_addr"}, longint'(rom_addr), 0);
  endtask

  // Assert reset mid-stream: everything in flight is discarded.
  task automatic do_reset();
    @(negedge clk);
    rst      = 1'b1;
    in_valid = 1'b0;
    in_sof   = 1'b1;
    #1;
    check_zero_outputs("mid_reset");
    exp_q.delete();
    exp_cyc_q.delete();
    mk = 0;
    @(negedge clk);
    in_sof = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(posedge clk) begin
    logic [4*DW-1:0] e;
    logic signed [DW-1:0] eur, eui, elr, eli;
    int ec;
    #1;
    if (!rst && out_valid) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_out: out_valid 1 with empty expected queue (cycle %0d)", cyc);
      end else begin
        e  = exp_q.pop_front();
        ec = exp_cyc_q.pop_front();
        {eur, eui, elr, eli} = e;
        check("latency", longint'(cyc), longint'(ec));
        check("out_up_r", longint'(out_up_r), longint'(eur));
        check("out_up_i", longint'(out_up_i), longint'(eui));
        check("out_lo_r", longint'(out_lo_r), longint'(elr));
        check("out_lo_i", longint'(out_lo_i), longint'(eli));
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    rst      = 1'b1;
    in_valid = 1'b0;
    in_sof   = 1'b0;
    in_up_r  = '0;
    in_up_i  = '0;
    in_lo_r  = '0;
    in_lo_i  = '0;
    repeat (2) @(negedge clk);
    #1;
    check_zero_outputs("reset");
    @(negedge clk);
    rst = 1'b0;

    // k=0 identity.
    drive(1'b1, 1'b1, 16'sd7, -16'sd7, 16'sd1000, -16'sd500, 1'b1, 16'sd1000, -16'sd500);

    // k=8: (100,200) * (0,-128) -> (200,-100).
    for (int i = 1; i < 8; i++) send(1'b0);
    drive(1'b1, 1'b0, 16'sd3, 16'sd4, 16'sd100, 16'sd200, 1'b1, 16'sd200, -16'sd100);

    // k=4 with (90,-90): rounding and saturation.
    send(1'b1);
    for (int i = 1; i < 4; i++) send(1'b0);
    drive(1'b1, 1'b0, 16'sd1, 16'sd2, 16'sd1000, 16'sd0, 1'b1, 16'sd703, -16'sd703);
    send(1'b1);
    for (int i = 1; i < 4; i++) send(1'b0);
    drive(1'b1, 1'b0, 16'sd5, 16'sd6, 16'sd32767, 16'sd32767, 1'b1, 16'sd32767, 16'sd0);

    // 17 valids, 3-cycle gap after k=6; rom_addr must hold at 7.
    for (int i = 0; i < 17; i++) begin
      send(i == 0);
      if (i == 6) begin
        idle(1'b0);
        idle(1'b1);
        idle(1'b0);
      end
    end

    // Restart mid-frame at counter 5; sof without valid is ignored.
    send(1'b1);
    for (int i = 1; i < 5; i++) send(1'b0);
    send(1'b1);
    send(1'b0);
    idle(1'b1);
    send(1'b0);

    // Randomized traffic with a reset in the middle.
    for (int i = 0; i < 500; i++) begin
      if (i == 250) begin
        do_reset();
        send(1'b0);   // first sample after reset must use k=0
      end
      if ($urandom_range(0, 9) < 7) send($urandom_range(0, 9) == 0);
      else idle($urandom_range(0, 3) == 0);
    end

    // Drain pipeline and confirm nothing is left outstanding.
    repeat (6) idle(1'b0);
    check("drain_queue_empty", longint'(exp_q.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
